// File: rtl/bit_serial_add.sv
// Bit-serial adder: one full_add cell walked LSB-first over width_p cycles,
// with valid/ready handshakes on both the request and result sides.

// Single-bit full adder cell; purely combinational.
module full_add (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    sum_o   = a_i ^ b_i ^ carry_i;
    carry_o = (a_i & b_i) | (a_i & carry_i) | (b_i & carry_i);
  end

endmodule

module bit_serial_add #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               carry_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] sum_o,
  output logic               carry_o
);

  localparam int unsigned cnt_w = $clog2(width_p + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] a_q, a_d;
  logic [width_p-1:0] b_q, b_d;
  logic [width_p-1:0] sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [cnt_w-1:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic               fa_sum;
  logic               fa_carry;

  // The one arithmetic cell, fed from the operand LSBs and the running carry.
  full_add u_full_add (
    .a_i     (a_q[0]),
    .b_i     (b_q[0]),
    .carry_i (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  // Next-state, datapath and handshake-flag decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        // Operands are captured only here; later input changes are ignored.
        if (valid_i && ready_q) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = carry_i;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after width_p shifts.
        a_d                 = a_q >> 1;
        b_d                 = b_q >> 1;
        sum_d               = sum_q >> 1;
        sum_d[width_p-1]    = fa_sum;
        carry_d             = fa_carry;
        count_d             = count_q + cnt_w'(1);
        if (count_q == cnt_w'(width_p - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Result held until the consumer takes it; no new accept on this edge.
        if (valid_q && ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags are registered copies of the next state, so they are mutually exclusive.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    ready_o = ready_q;
    valid_o = valid_q;
    sum_o   = sum_q;
    carry_o = carry_q;
  end

endmodule

// File: tb/tb_bit_serial_add.sv
// Directed and randomized checks of bit_serial_add at width 8.
module tb_bit_serial_add;

  localparam int unsigned W = 8;

  logic         clk_i;
  logic         reset_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         carry_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;

  int n_total;
  int n_bad;

  bit_serial_add #(.width_p(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One full request/result transaction; hold = DONE cycles with ready_i low.
  task automatic run_req(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input int hold, input bit poke);
    int         cyc;
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(cin);
    cyc = 0;
    while (!ready_o && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    carry_i = cin;
    tick();
    valid_i = 1'b0;
    a_i     = ~a;
    b_i     = 8'($urandom);
    carry_i = ~cin;
    chk({tag, "_busy"}, 64'({valid_o, ready_o}), 64'd0);
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(W));
    chk({tag, "_res"}, 64'({carry_o, sum_o}), 64'(exp));
    chk({tag, "_nrdy"}, 64'(ready_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        valid_i = 1'(i % 2);
      end
      tick();
      chk({tag, "_hold"}, 64'({valid_o, ready_o, carry_o, sum_o}), 64'({2'b10, exp}));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk({tag, "_idle"}, 64'({valid_o, ready_o}), 64'b01);
    chk({tag, "_keep"}, 64'({carry_o, sum_o}), 64'(exp));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    carry_i = 1'b0;

    // Reset held two cycles.
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_state", 64'({ready_o, valid_o, carry_o, sum_o}), 64'({2'b10, 1'b0, 8'h00}));

    // Directed vectors.
    run_req("basic", 8'h35, 8'h4A, 1'b0, 0, 1'b0);
    run_req("wrap1", 8'hFF, 8'h01, 1'b1, 0, 1'b0);
    run_req("wrap2", 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_req("zero",  8'h00, 8'h00, 1'b0, 0, 1'b0);
    run_req("msb",   8'h80, 8'h80, 1'b0, 1, 1'b0);
    run_req("alt",   8'hAA, 8'h55, 1'b1, 2, 1'b0);

    // Backpressure: five DONE cycles with ready_i low and valid_i pulsing.
    run_req("bp", 8'h12, 8'h34, 1'b1, 5, 1'b1);

    // Reset three edges into BUSY.
    valid_i = 1'b1;
    a_i     = 8'hC3;
    b_i     = 8'h5A;
    carry_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("midrst", 64'({ready_o, valid_o, carry_o, sum_o}), 64'({2'b10, 1'b0, 8'h00}));
    tick();
    chk("midrst_stay", 64'({ready_o, valid_o}), 64'b10);
    run_req("post_rst", 8'h10, 8'h20, 1'b0, 0, 1'b0);

    // Randomized requests with random DONE backpressure.
    for (int n = 0; n < 1000; n++) begin
      run_req("rnd", 8'($urandom), 8'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
